// File: rtl/dds_ctrl_pkg.sv
// Shared types and constants for the DDS parameter scheduler.
// Holds the sequencing state enum and the phase/degree arithmetic helpers.
package dds_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        DIV,
        CALC,
        COMMIT
    } state_t;

    localparam int QUAD_SPAN = 1024;
    localparam int AD_FULL   = 4095;
    localparam int FRAC_MAX  = 1023;
    localparam int DEG_MUL   = 45;
    localparam int DEG_SHIFT = 9;

    localparam int AD_W   = 12;
    localparam int PHA_W  = 12;
    localparam int DEG_W  = 9;
    localparam int FRAC_W = $clog2(QUAD_SPAN);
    localparam int DIV_W  = AD_W + FRAC_W;

    // ad=4095 divides to exactly QUAD_SPAN; clamp so it stays in its quadrant
    function automatic logic [FRAC_W-1:0] clamp_frac(input logic [DIV_W-1:0] q);
        return (q > DIV_W'(FRAC_MAX)) ? FRAC_W'(FRAC_MAX) : q[FRAC_W-1:0];
    endfunction

    function automatic logic [DEG_W-1:0] phase_to_deg(input logic [PHA_W-1:0] ph);
        logic [17:0] prod;
        prod = 18'(ph) * 18'(DEG_MUL);
        return DEG_W'(prod >> DEG_SHIFT);
    endfunction

endpackage

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per clock.
// done is high during the cycle that computes the last bit; quotient is final the cycle after.
module seq_divider #(
    parameter int DVD_W = 22,
    parameter int DVS_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic             done,
    output logic [DVD_W-1:0] quotient
);

    localparam int CNT_W = $clog2(DVD_W + 1);

    logic [DVS_W-1:0] rem;
    logic [DVD_W-1:0] quo;
    logic [DVS_W-1:0] dvs;
    logic [CNT_W-1:0] cnt;
    logic [DVS_W:0]   trial;
    logic             fits;
    logic [DVS_W-1:0] diff;

    assign trial = {rem, quo[DVD_W-1]};
    assign fits  = (trial >= {1'b0, dvs});
    // when fits, the true difference is below dvs so the low bits are exact
    assign diff  = trial[DVS_W-1:0] - dvs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem <= '0;
            quo <= '0;
            dvs <= '0;
            cnt <= '0;
        end else if (start) begin
            rem <= '0;
            quo <= dividend;
            dvs <= divisor;
            cnt <= CNT_W'(DVD_W);
        end else if (cnt != '0) begin
            rem <= fits ? diff : trial[DVS_W-1:0];
            quo <= {quo[DVD_W-2:0], fits};
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign done     = (cnt == CNT_W'(1));
    assign quotient = quo;

endmodule

// File: rtl/dds_param_sched.sv
// DDS parameter scheduler: periodic ADC sample -> frequency or phase word,
// committed on the DDS accumulator wrap (or after a bounded wait).
//
//   state  | meaning
//   IDLE   | waiting for a sample tick
//   REQ    | ad_req_out high, waiting for ad_valid_in
//   DIV    | scaling the sample into a quadrant fraction
//   CALC   | forming the new word(s)
//   COMMIT | waiting for dds_sync_in or timeout, then writing the outputs
module dds_param_sched
    import dds_ctrl_pkg::*;
#(
    parameter int SAMPLE_DIV   = 50000,
    parameter int FREQ_STEP    = 16,
    parameter int FW_W         = 32,
    parameter int SYNC_TIMEOUT = 4096
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             f_p_choose_in,
    input  logic             p_step_in,
    output logic             ad_req_out,
    input  logic             ad_valid_in,
    input  logic [AD_W-1:0]  ad_in,
    input  logic             dds_sync_in,
    output logic [FW_W-1:0]  freq_word_out,
    output logic [PHA_W-1:0] pha_word_out,
    output logic [PHA_W-1:0] pha_oled_out,
    output logic             upd_out,
    output logic             busy_out
);

    localparam int TICK_W = $clog2(SAMPLE_DIV);
    localparam int TMO_W  = $clog2(SYNC_TIMEOUT + 1);

    state_t            state;
    logic [TICK_W-1:0] tick_cnt;
    logic              tick;
    logic [1:0]        quad;
    logic [1:0]        quad_snap;
    logic              tgt_pha;
    logic [AD_W-1:0]   ad_lat;
    logic [TMO_W-1:0]  tmo_cnt;
    logic [PHA_W-1:0]  pha_next;
    logic [DEG_W-1:0]  deg_next;
    logic [FW_W-1:0]   freq_next;
    logic [PHA_W-1:0]  pha_q;
    logic [DEG_W-1:0]  deg_q;
    logic [FW_W-1:0]   freq_q;
    logic              div_start;
    logic              div_done;
    logic [DIV_W-1:0]  div_q;
    logic [PHA_W-1:0]  pha_calc;
    logic              commit;

    assign tick = (tick_cnt == TICK_W'(SAMPLE_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            tick_cnt <= '0;
        else if (tick)
            tick_cnt <= '0;
        else
            tick_cnt <= tick_cnt + TICK_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            quad <= '0;
        else if (p_step_in)
            quad <= quad + 2'd1;
    end

    // divider is launched on the same edge that latches the sample
    assign div_start = (state == REQ) && ad_valid_in && tgt_pha;

    seq_divider #(
        .DVD_W (DIV_W),
        .DVS_W (AD_W)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend ({ad_in, {FRAC_W{1'b0}}}),
        .divisor  (AD_W'(AD_FULL)),
        .done     (div_done),
        .quotient (div_q)
    );

    assign pha_calc = {quad_snap, clamp_frac(div_q)};
    assign commit   = (state == COMMIT) && (dds_sync_in || (tmo_cnt == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            quad_snap  <= '0;
            tgt_pha    <= 1'b0;
            ad_lat     <= '0;
            tmo_cnt    <= '0;
            pha_next   <= '0;
            deg_next   <= '0;
            freq_next  <= '0;
            pha_q      <= '0;
            deg_q      <= '0;
            freq_q     <= '0;
            ad_req_out <= 1'b0;
            busy_out   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (tick) begin
                        state      <= REQ;
                        quad_snap  <= quad;
                        tgt_pha    <= f_p_choose_in;
                        ad_req_out <= 1'b1;
                        busy_out   <= 1'b1;
                    end
                end
                REQ: begin
                    if (ad_valid_in) begin
                        ad_lat     <= ad_in;
                        ad_req_out <= 1'b0;
                        state      <= tgt_pha ? DIV : CALC;
                    end
                end
                DIV: begin
                    if (div_done)
                        state <= CALC;
                end
                CALC: begin
                    pha_next  <= pha_calc;
                    deg_next  <= phase_to_deg(pha_calc);
                    freq_next <= FW_W'(ad_lat) * FW_W'(FREQ_STEP);
                    tmo_cnt   <= TMO_W'(SYNC_TIMEOUT - 1);
                    state     <= COMMIT;
                end
                COMMIT: begin
                    if (commit) begin
                        if (tgt_pha) begin
                            pha_q <= pha_next;
                            deg_q <= deg_next;
                        end else begin
                            freq_q <= freq_next;
                        end
                        busy_out <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt - TMO_W'(1);
                    end
                end
                default: begin
                    state      <= IDLE;
                    ad_req_out <= 1'b0;
                    busy_out   <= 1'b0;
                end
            endcase
        end
    end

    // the committed value is visible during the commit cycle itself
    assign upd_out       = commit;
    assign freq_word_out = (commit && !tgt_pha) ? freq_next : freq_q;
    assign pha_word_out  = (commit && tgt_pha) ? pha_next : pha_q;
    assign pha_oled_out  = PHA_W'((commit && tgt_pha) ? deg_next : deg_q);

endmodule

// File: tb/tb_dds_param_sched.sv
// Bench for dds_param_sched: cycle-level timeline model plus directed literal checks.
module tb_dds_param_sched;

    localparam int SD = 100;
    localparam int ST = 20;
    localparam int FS = 16;
    localparam int FW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          f_p_choose_in = 1'b0;
    logic          p_step_in = 1'b0;
    logic          ad_valid_in = 1'b0;
    logic [11:0]   ad_in = '0;
    logic          dds_sync_in = 1'b0;
    logic          ad_req_out;
    logic [FW-1:0] freq_word_out;
    logic [11:0]   pha_word_out;
    logic [11:0]   pha_oled_out;
    logic          upd_out;
    logic          busy_out;

    dds_param_sched #(
        .SAMPLE_DIV   (SD),
        .FREQ_STEP    (FS),
        .FW_W         (FW),
        .SYNC_TIMEOUT (ST)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .f_p_choose_in (f_p_choose_in),
        .p_step_in     (p_step_in),
        .ad_req_out    (ad_req_out),
        .ad_valid_in   (ad_valid_in),
        .ad_in         (ad_in),
        .dds_sync_in   (dds_sync_in),
        .freq_word_out (freq_word_out),
        .pha_word_out  (pha_word_out),
        .pha_oled_out  (pha_oled_out),
        .upd_out       (upd_out),
        .busy_out      (busy_out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // stimulus control
    int          cyc_g = 0;
    int          valid_cyc = 0;
    int          upd_cyc = 0;
    bit          valid_flag = 0;
    int          vdelay = 1;
    int          req_cnt = 0;
    bit          prev_req = 0;
    int          req_rises = 0;
    int          sync_mode = 1;
    int          sync_at = -1;
    bit          spurious = 0;
    bit          fp_cfg = 0;
    logic [11:0] cur_ad = '0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // one clock of stimulus, driven at the falling edge
    task automatic tick_cycle(input bit pstep);
        @(negedge clk);
        cyc_g++;
        p_step_in     = pstep;
        f_p_choose_in = fp_cfg;
        ad_valid_in   = 1'b0;
        if (ad_req_out) begin
            if (!prev_req) req_rises++;
            if (req_cnt == vdelay) begin
                ad_valid_in = 1'b1;
                ad_in       = cur_ad;
                valid_cyc   = cyc_g;
                valid_flag  = 1;
                if (sync_mode == 3) sync_at = cyc_g + 33;
                req_cnt = 0;
            end else begin
                req_cnt++;
            end
        end else begin
            req_cnt = 0;
            if (spurious && $urandom_range(0, 19) == 0) begin
                ad_valid_in = 1'b1;
                ad_in       = 12'($urandom_range(0, 4095));
            end
        end
        prev_req = ad_req_out;
        case (sync_mode)
            0:       dds_sync_in = ($urandom_range(0, 9) == 0);
            1:       dds_sync_in = 1'b1;
            2:       dds_sync_in = 1'b0;
            default: dds_sync_in = (cyc_g == sync_at);
        endcase
    endtask

    task automatic wait_upd(input string name, input int budget);
        bit ok;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            tick_cycle(1'b0);
            #3;
            if (upd_out) begin
                ok = 1;
                upd_cyc = cyc_g;
                break;
            end
        end
        check({name, "_upd_seen"}, longint'(ok), 1);
    endtask

    // timeline model: sample ticks, request window, commit window and held words
    initial begin : model
        longint n, quad, snap_q, ad, cfrom, frac;
        longint e_fw, e_pw, e_dg, fw, pw, dg;
        bit     busy, req, snap_fp, commit, ok;
        n = 0; quad = 0; snap_q = 0; ad = 0; cfrom = -1;
        e_fw = 0; e_pw = 0; e_dg = 0; busy = 0; req = 0; snap_fp = 0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                n = 0; quad = 0; busy = 0; req = 0; cfrom = -1;
                e_fw = 0; e_pw = 0; e_dg = 0;
                ok = (ad_req_out == 0) && (busy_out == 0) && (upd_out == 0) &&
                     (freq_word_out == 0) && (pha_word_out == 0) && (pha_oled_out == 0);
                n_checks++;
                if (ok) n_pass++;
                else $display("FAIL reset_outputs t=%0t: req=%0b busy=%0b upd=%0b fw=%0d pw=%0d deg=%0d, expected all zero",
                              $time, ad_req_out, busy_out, upd_out, freq_word_out, pha_word_out, pha_oled_out);
            end else begin
                commit = busy && !req && (cfrom >= 0) && (n >= cfrom) &&
                         (dds_sync_in || (n == cfrom + ST - 1));
                fw = e_fw; pw = e_pw; dg = e_dg;
                if (commit) begin
                    if (snap_fp) begin
                        frac = (ad * 1024) / 4095;
                        if (frac > 1023) frac = 1023;
                        pw = snap_q * 1024 + frac;
                        dg = (pw * 45) / 512;
                    end else begin
                        fw = (ad * FS) % (64'd1 << FW);
                    end
                end
                ok = (ad_req_out == req) && (busy_out == busy) && (upd_out == commit) &&
                     (freq_word_out == fw) && (pha_word_out == pw) && (pha_oled_out == dg);
                n_checks++;
                if (ok) n_pass++;
                else $display("FAIL cycle_model n=%0d: got req=%0b busy=%0b upd=%0b fw=%0d pw=%0d deg=%0d, expected req=%0b busy=%0b upd=%0b fw=%0d pw=%0d deg=%0d",
                              n, ad_req_out, busy_out, upd_out, freq_word_out, pha_word_out, pha_oled_out,
                              req, busy, commit, fw, pw, dg);
                if (commit) begin
                    e_fw = fw; e_pw = pw; e_dg = dg;
                    busy = 0; cfrom = -1;
                end else if (!busy && (n % SD == SD - 1)) begin
                    busy = 1; req = 1; snap_q = quad; snap_fp = f_p_choose_in;
                end else if (req && ad_valid_in) begin
                    req = 0; ad = ad_in;
                    cfrom = n + (snap_fp ? 24 : 2);
                end
                if (p_step_in) quad = (quad + 1) % 4;
                n++;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        repeat (3) tick_cycle(1'b0);
        #3;
        check("rst_freq", freq_word_out, 0);
        check("rst_busy", busy_out, 0);
        check("rst_req", ad_req_out, 0);
        tick_cycle(1'b0);
        rst_n = 1'b1;

        // phase, quad 0, ad 2048, sync tied high
        sync_mode = 1; fp_cfg = 1; cur_ad = 12'd2048; vdelay = 2;
        wait_upd("ph2048", 300);
        check("ph2048_pw", pha_word_out, 512);
        check("ph2048_deg", pha_oled_out, 45);
        check("ph2048_lat", upd_cyc - valid_cyc, 24);

        // four steps wrap quad back to 0
        repeat (4) tick_cycle(1'b1);
        cur_ad = 12'd0;
        wait_upd("ph0", 300);
        check("ph0_pw", pha_word_out, 0);
        check("ph0_deg", pha_oled_out, 0);

        // two steps, full-scale sample clamps inside quadrant 2
        repeat (2) tick_cycle(1'b1);
        cur_ad = 12'd4095;
        wait_upd("ph4095", 300);
        check("ph4095_pw", pha_word_out, 3071);
        check("ph4095_deg", pha_oled_out, 269);

        // frequency target skips the divider
        fp_cfg = 0; cur_ad = 12'd100;
        wait_upd("fr100", 300);
        check("fr100_fw", freq_word_out, 1600);
        check("fr100_pw_hold", pha_word_out, 3071);
        check("fr100_lat", upd_cyc - valid_cyc, 2);

        // sync held low: timeout commit on the ST-th COMMIT cycle
        fp_cfg = 1; cur_ad = 12'd1000; sync_mode = 2;
        wait_upd("tmo", 300);
        check("tmo_lat", upd_cyc - valid_cyc, 24 + ST - 1);
        check("tmo_pw", pha_word_out, 2298);
        check("tmo_deg", pha_oled_out, 201);

        // single sync pulse on cycle 10 of COMMIT
        cur_ad = 12'd3000; sync_mode = 3;
        wait_upd("sync10", 300);
        check("sync10_lat", upd_cyc - valid_cyc, 33);
        check("sync10_pw", pha_word_out, 2798);
        check("sync10_deg", pha_oled_out, 245);

        // slow ADC: a tick lands while in REQ and must not start a second request
        sync_mode = 1; fp_cfg = 0; cur_ad = 12'd7; vdelay = 130; req_rises = 0;
        wait_upd("busytick", 400);
        check("busytick_rises", req_rises, 1);
        check("busytick_fw", freq_word_out, 112);
        vdelay = 1;

        // reset in the middle of the divide
        fp_cfg = 1; cur_ad = 12'd2000; valid_flag = 0;
        for (int i = 0; i < 300 && !valid_flag; i++) tick_cycle(1'b0);
        check("middiv_valid_seen", longint'(valid_flag), 1);
        repeat (10) tick_cycle(1'b0);
        #3;
        check("middiv_busy_before", busy_out, 1);
        tick_cycle(1'b0);
        rst_n = 1'b0;
        #3;
        check("middiv_pw", pha_word_out, 0);
        check("middiv_deg", pha_oled_out, 0);
        check("middiv_fw", freq_word_out, 0);
        for (int i = 0; i < 3; i++) begin
            tick_cycle(1'b0);
            #3;
            check("middiv_no_upd", upd_out, 0);
        end
        tick_cycle(1'b0);
        rst_n = 1'b1;

        // randomized run against the model
        sync_mode = 0; spurious = 1;
        for (int i = 0; i < 3000; i++) begin
            int r;
            if (!ad_req_out) vdelay = $urandom_range(0, 4);
            if ($urandom_range(0, 29) == 0) fp_cfg = ~fp_cfg;
            r = $urandom_range(0, 9);
            cur_ad = (r == 0) ? 12'd0 : (r == 1) ? 12'd4095 : 12'($urandom_range(0, 4095));
            tick_cycle($urandom_range(0, 11) == 0);
        end
        tick_cycle(1'b0);
        #3;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
